// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - framebuffer write scheduler: pixel FIFO plus fill sequencer, writes only during blanking
module fb_write_scheduler #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FB_SIZE    = 307200
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_n,
    input  logic                          iBLANK_n,
    input  logic                          iWR_REQ,
    input  logic [ADDR_W-1:0]             iWR_ADDR,
    input  logic [DATA_W-1:0]             iWR_DATA,
    output logic                          oWR_READY,
    input  logic                          iCLR_REQ,
    input  logic [DATA_W-1:0]             iCLR_DATA,
    output logic                          oCLR_BUSY,
    output logic [ADDR_W-1:0]             oRAM_ADDR,
    output logic [DATA_W-1:0]             oRAM_DATA,
    output logic                          oRAM_WREN,
    output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
    output logic                          oOVERFLOW
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   clr_data;
    logic                full;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    // Readiness is judged on the pre-pop level, so a full FIFO drops even when popping.
    assign full      = (level == LVL_FULL);
    assign push      = iWR_REQ && !full;
    assign pop       = (state == DRAIN) && !iBLANK_n && (level != '0);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    assign oWR_READY   = !full;
    assign oFIFO_LEVEL = level;

    always_ff @(posedge iVGA_CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= iWR_ADDR;
            fifo_data[wr_ptr] <= iWR_DATA;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            clr_cnt   <= '0;
            clr_data  <= '0;
            oCLR_BUSY <= 1'b0;
            oRAM_ADDR <= '0;
            oRAM_DATA <= '0;
            oRAM_WREN <= 1'b0;
            oOVERFLOW <= 1'b0;
        end else begin
            oRAM_WREN <= 1'b0;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (pop && !push) level <= level - LVL_W'(1);
            if (iWR_REQ && full) oOVERFLOW <= 1'b1;

            case (state)
                IDLE: begin
                    if (iCLR_REQ) begin
                        state     <= CLEAR;
                        clr_data  <= iCLR_DATA;
                        clr_cnt   <= '0;
                        oCLR_BUSY <= 1'b1;
                    end else if (level != '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Out-of-range entries are consumed silently.
                    if (pop && (head_addr <= FB_LAST)) begin
                        oRAM_WREN <= 1'b1;
                        oRAM_ADDR <= head_addr;
                        oRAM_DATA <= head_data;
                    end
                    if (iCLR_REQ) begin
                        state     <= CLEAR;
                        clr_data  <= iCLR_DATA;
                        clr_cnt   <= '0;
                        oCLR_BUSY <= 1'b1;
                    end else if (level == '0) begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (!iBLANK_n) begin
                        oRAM_WREN <= 1'b1;
                        oRAM_ADDR <= clr_cnt;
                        oRAM_DATA <= clr_data;
                        if (clr_cnt == FB_LAST) begin
                            state     <= IDLE;
                            oCLR_BUSY <= 1'b0;
                        end else begin
                            clr_cnt <= clr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - directed self-checking bench for fb_write_scheduler
module tb_fb_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        blank_n = 1'b1;
    logic        wr_req = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        clr_req = 1'b0;
    logic [7:0]  clr_data = '0;
    logic        clr_busy;
    logic [18:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [4:0]  fifo_level;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    fb_write_scheduler #(.FB_SIZE(100)) dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iBLANK_n    (blank_n),
        .iWR_REQ     (wr_req),
        .iWR_ADDR    (wr_addr),
        .iWR_DATA    (wr_data),
        .oWR_READY   (wr_ready),
        .iCLR_REQ    (clr_req),
        .iCLR_DATA   (clr_data),
        .oCLR_BUSY   (clr_busy),
        .oRAM_ADDR   (ram_addr),
        .oRAM_DATA   (ram_data),
        .oRAM_WREN   (ram_wren),
        .oFIFO_LEVEL (fifo_level),
        .oOVERFLOW   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int d);
        wr_req  = 1'b1;
        wr_addr = 19'(a);
        wr_data = 8'(d);
        step();
        wr_req  = 1'b0;
    endtask

    initial begin
        int  nw;
        int  k;
        bit  found;

        // asynchronous reset, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_wren",  32'(ram_wren),   0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready", 32'(wr_ready),   1);
        chk("rst_busy",  32'(clr_busy),   0);
        chk("rst_ovf",   32'(overflow),   0);
        #8 rst_n = 1'b1;

        // buffered writes held off by active video
        blank_n = 1'b1;
        push(10, 8'h05);
        chk("buf_wren0", 32'(ram_wren), 0);
        push(11, 8'h06);
        push(12, 8'h07);
        chk("buf_level3", 32'(fifo_level), 3);
        step();
        chk("buf_active_nowren", 32'(ram_wren), 0);
        blank_n = 1'b0;
        step();
        chk("buf_w0_en", 32'(ram_wren), 1);
        chk("buf_w0_a",  32'(ram_addr), 10);
        chk("buf_w0_d",  32'(ram_data), 8'h05);
        step();
        chk("buf_w1_en", 32'(ram_wren), 1);
        chk("buf_w1_a",  32'(ram_addr), 11);
        chk("buf_w1_d",  32'(ram_data), 8'h06);
        step();
        chk("buf_w2_en", 32'(ram_wren), 1);
        chk("buf_w2_a",  32'(ram_addr), 12);
        chk("buf_w2_d",  32'(ram_data), 8'h07);
        chk("buf_level0", 32'(fifo_level), 0);
        step();
        chk("buf_done_wren", 32'(ram_wren), 0);
        chk("buf_hold_a",    32'(ram_addr), 12);

        // overflow: 17 pushes into a 16-entry FIFO during active video
        blank_n = 1'b1;
        for (int i = 0; i < 16; i++) push(20 + i, i);
        chk("ovf_level16", 32'(fifo_level), 16);
        chk("ovf_ready0",  32'(wr_ready),   0);
        chk("ovf_flag0",   32'(overflow),   0);
        push(36, 16);
        chk("ovf_level_kept", 32'(fifo_level), 16);
        chk("ovf_flag1",      32'(overflow),   1);
        blank_n = 1'b0;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (ram_wren) begin
                chk("ovf_drain_a", 32'(ram_addr), 32'(20 + k));
                chk("ovf_drain_d", 32'(ram_data), 32'(k));
                k++;
            end
        end
        chk("ovf_drain_count", 32'(k), 16);
        chk("ovf_sticky",      32'(overflow), 1);
        chk("ovf_ready1",      32'(wr_ready), 1);

        // gated fill with FIFO traffic pushed meanwhile
        blank_n  = 1'b1;
        clr_req  = 1'b1;
        clr_data = 8'h3C;
        step();
        clr_req  = 1'b0;
        chk("fill_busy1", 32'(clr_busy), 1);
        nw = 0;
        for (int c = 0; c < 400; c++) begin
            blank_n = ((c % 20) < 7) ? 1'b0 : 1'b1;
            wr_req  = (c == 3) || (c == 4);
            wr_addr = (c == 3) ? 19'd5 : 19'd150;
            wr_data = (c == 3) ? 8'h01 : 8'h09;
            clr_req = (c == 50);
            clr_data = 8'hAA;
            step();
            if (ram_wren) begin
                chk("fill_gate", 32'(blank_n), 0);
                if (nw < 100) begin
                    chk("fill_a", 32'(ram_addr), 32'(nw));
                    chk("fill_d", 32'(ram_data), 8'h3C);
                    if (nw == 99) chk("fill_busy_fall", 32'(clr_busy), 0);
                end else begin
                    chk("after_fill_a", 32'(ram_addr), 5);
                    chk("after_fill_d", 32'(ram_data), 8'h01);
                end
                nw++;
            end
        end
        wr_req  = 1'b0;
        clr_req = 1'b0;
        chk("fill_total_writes", 32'(nw), 101);
        chk("fill_level0",       32'(fifo_level), 0);
        chk("fill_busy_end",     32'(clr_busy), 0);

        // reset in the middle of a fill
        blank_n  = 1'b0;
        clr_req  = 1'b1;
        clr_data = 8'h11;
        step();
        clr_req  = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            if (ram_wren && ram_addr == 19'd39) found = 1'b1;
        end
        chk("mid_reached_39", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wren", 32'(ram_wren), 0);
        chk("mid_rst_busy", 32'(clr_busy), 0);
        chk("mid_rst_ovf",  32'(overflow), 0);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mid_idle_wren", 32'(ram_wren), 0);
        end
        clr_req  = 1'b1;
        clr_data = 8'h22;
        step();
        clr_req  = 1'b0;
        step();
        chk("restart_en",   32'(ram_wren), 1);
        chk("restart_a",    32'(ram_addr), 0);
        chk("restart_d",    32'(ram_data), 8'h22);
        chk("restart_busy", 32'(clr_busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
Schedules all writes into the single-port 8-bit colour-index framebuffer RAM (640x480, 19-bit address) that the VGA scanout reads during active video.
- Buffers pixel writes from the paint logic in a small FIFO.
- Runs a full-screen clear/fill sequencer.
- Issues RAM writes only while the display is blanked, so scanout reads are never disturbed.
- Sits between the paint processor and the framebuffer RAM's address/data/wren inputs, in the VGA clock domain.

Parameters:
ADDR_W, 19, framebuffer address width
DATA_W, 8, colour-index width
FIFO_DEPTH, 16, pixel-write FIFO entries (power of two)
FB_SIZE, 307200, number of framebuffer locations (640*480)

Ports:
iVGA_CLK  in  1  VGA pixel clock; all logic on its rising edge
iRST_n  in  1  asynchronous active-low reset
iBLANK_n  in  1  early (undelayed) blank from the sync generator; 1 = active video, RAM owned by scanout
iWR_REQ  in  1  pixel write request; accepted when oWR_READY=1
iWR_ADDR  in  ADDR_W  pixel address
iWR_DATA  in  DATA_W  pixel colour index
oWR_READY  out  1  FIFO not full
iCLR_REQ  in  1  start full-screen fill (level-sampled; acts as a pulse)
iCLR_DATA  in  DATA_W  fill colour index, captured at accept
oCLR_BUSY  out  1  fill in progress
oRAM_ADDR  out  ADDR_W  write address to framebuffer
oRAM_DATA  out  DATA_W  write data to framebuffer
oRAM_WREN  out  1  write strobe; framebuffer address mux selects oRAM_ADDR when high
oFIFO_LEVEL  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
oOVERFLOW  out  1  sticky: a write was offered while the FIFO was full

Behaviour:
Reset values:
- All outputs 0, except oWR_READY=1.
- FIFO empty; state IDLE.
- Reset is asynchronous and may occur mid-operation: it aborts any fill, empties the FIFO and clears oOVERFLOW.

FIFO:
- Push when iWR_REQ=1 and level<FIFO_DEPTH.
- iWR_REQ=1 while full: write dropped, level unchanged, oOVERFLOW set until reset.
- Push and pop in the same cycle: level unchanged. A push into a full FIFO with a simultaneous pop is still a drop, because readiness is judged on the pre-pop level.
- oWR_READY = (level != FIFO_DEPTH), combinational from the level register.

States:
- IDLE:
  - iCLR_REQ=1 -> CLEAR: capture iCLR_DATA, clear counter=0, oCLR_BUSY=1.
  - Else, if FIFO non-empty -> DRAIN.
- DRAIN:
  - Each cycle with iBLANK_n=0 and FIFO non-empty, pop one entry.
  - iCLR_REQ=1 -> CLEAR after the current pop; the FIFO remains intact.
  - FIFO empty -> IDLE.
- CLEAR:
  - Each cycle with iBLANK_n=0, write the fill colour at the counter address and increment the counter.
  - When the write to address FB_SIZE-1 is issued -> IDLE, and oCLR_BUSY falls on the same edge.
  - iCLR_REQ while busy is ignored.
  - FIFO pushes are accepted but not drained during CLEAR, so strokes issued after a clear land on top of it.

Write issue:
- Outputs are registered. The decision is made from iBLANK_n at edge t; oRAM_WREN/ADDR/DATA are valid for the cycle following edge t, with 1-cycle latency.
- iBLANK_n must be the early blank; the display path delays it, so writes always fall inside blanking.
- oRAM_WREN is high for exactly one cycle per write.
- Throughput is one write per blank cycle, in FIFO order.
- Popped entries with address >= FB_SIZE are discarded: popped, no WREN.
- No write is ever issued in a cycle following iBLANK_n=1 sampled at the decision edge.
- oRAM_ADDR/oRAM_DATA hold their last value when oRAM_WREN=0.

Test Plan:
- Reset check: assert iRST_n=0 asynchronously mid-cycle -> oRAM_WREN=0, oFIFO_LEVEL=0, oWR_READY=1, oCLR_BUSY=0, oOVERFLOW=0 immediately.
- Buffered writes: push (10,0x05), (11,0x06), (12,0x07) with iBLANK_n=1 -> no WREN and level=3. Then drop iBLANK_n to 0 -> WREN on 3 consecutive cycles with addr 10,11,12 and data 05,06,07 in order; level returns to 0.
- Overflow: hold iBLANK_n=1 and push 17 writes -> level=16, oWR_READY=0 after the 16th, the 17th is dropped, oOVERFLOW=1. Then blank -> exactly 16 writes issued.
- Blank gating of a fill (FB_SIZE=100): pulse iCLR_REQ with iCLR_DATA=0x3C; toggle iBLANK_n in 7-cycle blank / 13-cycle active windows -> exactly 100 WRENs, addresses 0..99, all data 0x3C, none following an active-sampled edge. oCLR_BUSY falls at the last write.
- Clear/FIFO ordering and range checks:
  - Push (5,0x01) during CLEAR -> it is written after address 99 and is never overwritten.
  - Pushing address 150 pops with no WREN.
- Mid-fill reset: assert reset at counter=40 -> WREN stops, oCLR_BUSY=0. A new iCLR_REQ restarts at address 0.
